// File: rtl/bcd_to_bin_if.sv
// Handshake and data bundle between a BCD-to-binary requester and the converter.
interface bcd_to_bin_if;
    logic        start;
    logic [39:0] bcd;
    logic        sign;
    logic [31:0] bin;
    logic        err;
    logic        done;
    logic        ready;

    modport master (
        output start, bcd, sign,
        input  bin, err, done, ready
    );

    modport slave (
        input  start, bcd, sign,
        output bin, err, done, ready
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential 10-digit signed BCD to 32-bit two's-complement converter.
// Uses reverse double dabble: 34 right shifts of {bcd_reg, acc_reg}, with
// every digit >= 8 reduced by 3 after each shift. Result is saturated to an
// error when a digit is invalid or the magnitude does not fit in 32 bits.
module bcd_to_bin (
    input  logic         clk,
    input  logic         rst,
    bcd_to_bin_if.slave  bus
);
    typedef enum logic [1:0] {
        READY  = 2'd0,
        DABBLE = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  count_reg;
    logic [39:0] bcd_reg;
    logic [33:0] acc_reg;
    logic        sign_reg;
    logic        bad_reg;
    logic [31:0] bin_reg;
    logic        err_reg;
    logic        done_reg;

    logic [39:0] bcd_shift;
    logic [39:0] bcd_adj;
    logic [9:0]  digit_bad;
    logic        ovf;

    assign bcd_shift = bcd_reg >> 1;

    // Per-digit correction after the shift and per-digit validity of the input.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_shift[4*gi +: 4] >= 4'd8)
                                      ? (bcd_shift[4*gi +: 4] - 4'd3)
                                      : bcd_shift[4*gi +: 4];
            assign digit_bad[gi] = (bus.bcd[4*gi +: 4] > 4'd9);
        end
    endgenerate

    // Negative results may reach 2^31; positive ones stop at 2^31-1.
    assign ovf = sign_reg ? (acc_reg > 34'd2147483648)
                          : (acc_reg > 34'd2147483647);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= READY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the spare encoding falls back to READY.
    always_comb begin
        state_next = READY;
        case (state_reg)
            READY:   state_next = bus.start ? DABBLE : READY;
            DABBLE:  state_next = (count_reg == 6'd0) ? FINISH : DABBLE;
            FINISH:  state_next = READY;
            default: state_next = READY;
        endcase
    end

    // Output logic: ready only when idle and no request is being presented.
    always_comb begin
        bus.ready = (state_reg == READY) && !bus.start;
    end

    // Datapath: capture, shift/correct, and final sign/range handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 6'd0;
            bcd_reg   <= 40'd0;
            acc_reg   <= 34'd0;
            sign_reg  <= 1'b0;
            bad_reg   <= 1'b0;
            bin_reg   <= 32'd0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= (state_reg == FINISH);
            case (state_reg)
                READY: begin
                    if (bus.start) begin
                        bcd_reg   <= bus.bcd;
                        acc_reg   <= 34'd0;
                        sign_reg  <= bus.sign;
                        bad_reg   <= |digit_bad;
                        count_reg <= 6'd33;
                    end
                end
                DABBLE: begin
                    bcd_reg   <= bcd_adj;
                    acc_reg   <= {bcd_reg[0], acc_reg[33:1]};
                    count_reg <= count_reg - 6'd1;
                end
                FINISH: begin
                    if (bad_reg || ovf) begin
                        bin_reg <= 32'd0;
                        err_reg <= 1'b1;
                    end else begin
                        bin_reg <= sign_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
                        err_reg <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bin  = bin_reg;
    assign bus.err  = err_reg;
    assign bus.done = done_reg;
endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port: start  input  1  request conversion; sampled only while in READY.
REQ-005 SHALL have port: bcd  input  40  10 BCD digits, digit i at bits [4i+3:4i], digit 0 least significant.
REQ-006 SHALL have port: sign  input  1  1 = negative magnitude.
REQ-007 SHALL have port: bin  output  32  signed two's-complement result, registered.
REQ-008 SHALL have port: err  output  1  registered; 1 = last result invalid (bad digit or out of range).
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking new bin/err.
REQ-010 SHALL have port: ready  output  1  combinational, equal to (state == READY && !start).
REQ-011 SHALL have parameter: none; widths fixed at 10 digits in and 32 bits out.

Function
REQ-012 SHALL implement states READY, DABBLE and FINISH, with a 6-bit countdown.
REQ-013 In READY with start=1, SHALL, on the edge, latch bcd into a 40-bit shift register, clear a 34-bit accumulator, latch sign, latch bad = (any digit > 9), set countdown=33 and go to DABBLE.
REQ-014 In READY with start=0, SHALL remain in READY with all registers held.
REQ-015 In DABBLE, each edge SHALL shift {bcdreg, acc} right by one: acc <= {bcdreg[0], acc[33:1]}.
REQ-016 In DABBLE, on the same edge, every 4-bit digit of (bcdreg >> 1) that is >= 8 SHALL be reduced by 3 before storing.
REQ-017 In DABBLE, SHALL decrement countdown each edge, and go to FINISH on the edge where countdown == 0, giving exactly 34 shift steps.
REQ-018 After the 34 steps, acc SHALL equal the binary magnitude of the latched BCD value (0..9999999999), provided bad=0.
REQ-019 In FINISH, SHALL set ovf = (sign=0 and acc > 2147483647) or (sign=1 and acc > 2147483648).
REQ-020 In FINISH with bad or ovf, SHALL set bin <= 0 and err <= 1.
REQ-021 In FINISH otherwise, SHALL set bin <= sign ? -acc[31:0] : acc[31:0] and err <= 0; sign=1 with magnitude 0 SHALL give bin=0, err=0.
REQ-022 In FINISH, SHALL set done <= 1 and go to READY; done SHALL be 0 on every other edge.
REQ-023 Latency: start sampled at edge E0 SHALL give done=1 and valid bin/err in the cycle after edge E35 (35 clocks), with ready=1 in that same cycle unless start is high.
REQ-024 start SHALL be ignored in DABBLE and FINISH; bcd and sign changes after E0 SHALL not affect the result.
REQ-025 start held high SHALL produce back-to-back conversions: a new conversion is sampled on the edge after done rises (E36), with done and the new start in the same cycle.
REQ-026 bin and err SHALL hold their value until the next FINISH.
REQ-027 Any unreachable state encoding SHALL return to READY on the next edge.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=READY, countdown=0, bin=0, err=0, done=0, and clear the internal shift and accumulator registers.
REQ-029 rst asserted mid-conversion SHALL abort it with no done pulse.
REQ-030 The first start after rst deasserts SHALL convert normally.

Verification
REQ-031 bcd=0x0000012345, sign=0, start pulse SHALL give done exactly 35 clocks later with bin=0x00003039 and err=0.
REQ-032 bcd=0x2147483648, sign=1 SHALL give bin=0x80000000 and err=0; the same value with sign=0 SHALL give bin=0 and err=1.
REQ-033 bcd=0x9999999999, sign=0 SHALL give err=1 and bin=0; bcd=0x00000000A0 SHALL give err=1 (bad digit).
REQ-034 bcd=0, sign=1 SHALL give bin=0 and err=0; bcd=0x2147483647, sign=1 SHALL give bin=0x80000001.
REQ-035 rst pulsed 10 clocks after start SHALL give no done, bin=0, and a correct next conversion.
REQ-036 start held high over 3 conversions with inputs changed mid-run SHALL give done every 36 clocks, each result matching the inputs at its own sampling edge.
